// File: rtl/cpu7_pkg.sv
// rtl/cpu7_pkg.sv - loader state encoding and error codes shared by the cpu7 program loader.
// S_CSUM exists only when PROG_LOADER_CHECKSUM_EN is defined.
package cpu7_pkg;

`ifdef PROG_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN_LO  = 3'd1,
      S_LEN_HI  = 3'd2,
      S_DATA_LO = 3'd3,
      S_DATA_HI = 3'd4,
      S_CSUM    = 3'd5,
      S_DONE    = 3'd6,
      S_ERR     = 3'd7
   } loader_state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN_LO  = 3'd1,
      S_LEN_HI  = 3'd2,
      S_DATA_LO = 3'd3,
      S_DATA_HI = 3'd4,
      S_DONE    = 3'd6,
      S_ERR     = 3'd7
   } loader_state_t;
`endif

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_LEN_ZERO = 3'd1;
   localparam logic [2:0] ERR_LEN_OVF  = 3'd2;
   localparam logic [2:0] ERR_CSUM     = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

   // Everything other than the three resting states is part of an active load.
   function automatic logic is_loading(input loader_state_t s);
      return !(s == S_IDLE || s == S_DONE || s == S_ERR);
   endfunction

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - UART byte-stream program loader writing 16-bit words into cpu7 program BRAM.
// Optional trailing XOR checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
   import cpu7_pkg::*;
#(
   parameter int          PROGRAM_SIZE   = 1024,
   parameter logic [7:0]  MAGIC          = 8'hA5,
   parameter int          TIMEOUT_CYCLES = 1000000
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [7:0]                      rx_data,
   input  logic                            rx_valid,
   output logic                            rx_ready,
   output logic                            mem_we,
   output logic [$clog2(PROGRAM_SIZE)-1:0] mem_addr,
   output logic [15:0]                     mem_wdata,
   output logic                            cpu_rst_n,
   output logic                            busy,
   output logic                            done,
   output logic [2:0]                      err
);

   localparam int              AW        = $clog2(PROGRAM_SIZE);
   localparam int              CW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [16:0]     MAX_WORDS = 17'(PROGRAM_SIZE);
   localparam logic [CW-1:0]   CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);

   loader_state_t state, state_next;
   logic [AW-1:0] idx, idx_next;
   logic [15:0]   left, left_next;
   logic [7:0]    len_lo, len_lo_next;
   logic [7:0]    word_lo, word_lo_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [2:0]    err_next;
   logic          we_next;
   logic [AW-1:0] addr_next;
   logic [15:0]   wdata_next;
   logic [15:0]   len_word;
   logic          accept;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]    csum, csum_next;
`endif

   assign rx_ready = 1'b1;
   assign accept   = rx_valid;
   assign len_word = {rx_data, len_lo};

   always_comb begin
      state_next   = state;
      idx_next     = idx;
      left_next    = left;
      len_lo_next  = len_lo;
      word_lo_next = word_lo;
      cnt_next     = busy ? cnt + CW'(1) : cnt;
      err_next     = err;
      we_next      = 1'b0;
      addr_next    = mem_addr;
      wdata_next   = mem_wdata;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_next    = csum;
`endif
      if (accept) begin
         cnt_next = '0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (rx_data == MAGIC) begin
                  state_next = S_LEN_LO;
                  err_next   = ERR_NONE;
                  idx_next   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                  csum_next  = '0;
`endif
               end
            end
            S_LEN_LO: begin
               len_lo_next = rx_data;
               state_next  = S_LEN_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
               csum_next   = csum ^ rx_data;
`endif
            end
            S_LEN_HI: begin
`ifdef PROG_LOADER_CHECKSUM_EN
               csum_next = csum ^ rx_data;
`endif
               if (len_word == 16'd0) begin
                  state_next = S_ERR;
                  err_next   = ERR_LEN_ZERO;
               end else if ({1'b0, len_word} > MAX_WORDS) begin
                  state_next = S_ERR;
                  err_next   = ERR_LEN_OVF;
               end else begin
                  left_next  = len_word;
                  state_next = S_DATA_LO;
               end
            end
            S_DATA_LO: begin
               word_lo_next = rx_data;
               state_next   = S_DATA_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
               csum_next    = csum ^ rx_data;
`endif
            end
            S_DATA_HI: begin
`ifdef PROG_LOADER_CHECKSUM_EN
               csum_next  = csum ^ rx_data;
`endif
               we_next    = 1'b1;
               addr_next  = idx;
               wdata_next = {rx_data, word_lo};
               idx_next   = idx + AW'(1);
               left_next  = left - 16'd1;
               if (left == 16'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                  state_next = S_CSUM;
`else
                  state_next = S_DONE;
`endif
               end else begin
                  state_next = S_DATA_LO;
               end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (rx_data == csum) begin
                  state_next = S_DONE;
               end else begin
                  state_next = S_ERR;
                  err_next   = ERR_CSUM;
               end
            end
`endif
            default: state_next = S_IDLE;
         endcase
      end else if (busy && cnt == CNT_LAST) begin
         // An accepted byte on this same edge takes the branch above instead.
         state_next = S_ERR;
         err_next   = ERR_TIMEOUT;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         idx       <= '0;
         left      <= '0;
         len_lo    <= '0;
         word_lo   <= '0;
         cnt       <= '0;
         err       <= ERR_NONE;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cpu_rst_n <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         state     <= state_next;
         idx       <= idx_next;
         left      <= left_next;
         len_lo    <= len_lo_next;
         word_lo   <= word_lo_next;
         cnt       <= cnt_next;
         err       <= err_next;
         mem_we    <= we_next;
         mem_addr  <= addr_next;
         mem_wdata <= wdata_next;
         busy      <= is_loading(state_next);
         done      <= (state_next == S_DONE);
         // The cpu leaves reset only once a complete image has been accepted.
         cpu_rst_n <= (state_next == S_DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
         csum      <= csum_next;
`endif
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - table-driven frame vectors plus timeout, maximum-length and reset sequences.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        cpu_rst_n;
   logic        busy;
   logic        done;
   logic [2:0]  err;

   always #5 clk = ~clk;

   prog_loader #(
      .PROGRAM_SIZE   (1024),
      .MAGIC          (8'hA5),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_rst_n (cpu_rst_n),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   typedef struct packed {
      logic [7:0]  nb;
      logic [95:0] seq;
      logic [1:0]  nw;
      logic [9:0]  a0;
      logic [15:0] d0;
      logic [9:0]  a1;
      logic [15:0] d1;
      logic        done;
      logic [2:0]  err;
   } vec_t;

   vec_t        tbl [0:6];
   string       names [0:6];
   int          total = 0;
   int          passed = 0;
   logic [25:0] wq [$];
   logic [25:0] exp_q [$];

   always @(negedge clk) if (mem_we) wq.push_back({mem_addr, mem_wdata});

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int          nb;
      int          bad;
      logic [7:0]  lo, hi, cs;
      logic [15:0] d;

`ifdef PROG_LOADER_CHECKSUM_EN
      tbl[0] = '{8'd8, 96'hA5_02_00_34_12_78_56_0A, 2'd2, 10'd0, 16'h1234, 10'd1, 16'h5678, 1'b1, 3'd0};
      tbl[3] = '{8'd6, 96'hA5_01_00_A5_00_A4, 2'd1, 10'd0, 16'h00A5, 10'd0, 16'h0, 1'b1, 3'd0};
      tbl[4] = '{8'd8, 96'h11_22_A5_01_00_EF_BE_50, 2'd1, 10'd0, 16'hBEEF, 10'd0, 16'h0, 1'b1, 3'd0};
      tbl[6] = '{8'd6, 96'hA5_01_00_CD_AB_00, 2'd1, 10'd0, 16'hABCD, 10'd0, 16'h0, 1'b0, 3'd3};
`else
      tbl[0] = '{8'd7, 96'hA5_02_00_34_12_78_56, 2'd2, 10'd0, 16'h1234, 10'd1, 16'h5678, 1'b1, 3'd0};
      tbl[3] = '{8'd5, 96'hA5_01_00_A5_00, 2'd1, 10'd0, 16'h00A5, 10'd0, 16'h0, 1'b1, 3'd0};
      tbl[4] = '{8'd7, 96'h11_22_A5_01_00_EF_BE, 2'd1, 10'd0, 16'hBEEF, 10'd0, 16'h0, 1'b1, 3'd0};
      tbl[6] = '{8'd6, 96'hA5_01_00_CD_AB_00, 2'd1, 10'd0, 16'hABCD, 10'd0, 16'h0, 1'b1, 3'd0};
`endif
      tbl[1] = '{8'd3, 96'hA5_00_00, 2'd0, 10'd0, 16'h0, 10'd0, 16'h0, 1'b0, 3'd1};
      tbl[2] = '{8'd3, 96'hA5_01_04, 2'd0, 10'd0, 16'h0, 10'd0, 16'h0, 1'b0, 3'd2};
      tbl[5] = '{8'd6, 96'hA5_01_00_CD_AB_67, 2'd1, 10'd0, 16'hABCD, 10'd0, 16'h0, 1'b1, 3'd0};
      names = '{"two_words", "len_zero", "len_ovf", "magic_as_data", "junk_then_frame",
                "csum_ok", "csum_bad"};

      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (2) @(negedge clk);
      check("rst.rx_ready", rx_ready, 1);
      check("rst.mem_we", mem_we, 0);
      check("rst.mem_addr", mem_addr, 0);
      check("rst.mem_wdata", mem_wdata, 0);
      check("rst.cpu_rst_n", cpu_rst_n, 0);
      check("rst.busy", busy, 0);
      check("rst.done", done, 0);
      check("rst.err", err, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 7; v++) begin
         wq.delete();
         nb = int'(tbl[v].nb);
         for (int k = 0; k < nb; k++) send(tbl[v].seq[(nb - 1 - k) * 8 +: 8]);
         idle(3);
         check({names[v], ".writes"}, wq.size(), tbl[v].nw);
         if (tbl[v].nw > 0 && wq.size() > 0) check({names[v], ".w0"}, wq[0], {tbl[v].a0, tbl[v].d0});
         if (tbl[v].nw > 1 && wq.size() > 1) check({names[v], ".w1"}, wq[1], {tbl[v].a1, tbl[v].d1});
         check({names[v], ".done"}, done, tbl[v].done);
         check({names[v], ".err"}, err, tbl[v].err);
         check({names[v], ".cpu_rst_n"}, cpu_rst_n, tbl[v].done);
         check({names[v], ".busy"}, busy, 0);
      end

      // Largest legal image: every address from 0 to PROGRAM_SIZE-1 written once.
      wq.delete();
      exp_q.delete();
      send(8'hA5); send(8'h00); send(8'h04);
      cs = 8'h04;
      for (int i = 0; i < 1024; i++) begin
         d  = 16'(i * 251 + 7);
         lo = d[7:0];
         hi = d[15:8];
         cs = cs ^ lo ^ hi;
         exp_q.push_back({10'(i), d});
         send(lo);
         send(hi);
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      send(cs);
`endif
      idle(3);
      check("maxlen.writes", wq.size(), 1024);
      bad = 0;
      for (int i = 0; i < 1024 && i < wq.size(); i++) if (wq[i] !== exp_q[i]) bad++;
      check("maxlen.content", bad, 0);
      check("maxlen.done", done, 1);
      check("maxlen.err", err, 0);

      // Silence after LEN_LO: error exactly TIMEOUT_CYCLES clocks after the byte.
      wq.delete();
      send(8'hA5);
      check("load.busy", busy, 1);
      check("load.done", done, 0);
      check("load.cpu_rst_n", cpu_rst_n, 0);
      send(8'h01);
      idle(15);
      check("tmo.err_before", err, 0);
      check("tmo.busy_before", busy, 1);
      idle(1);
      check("tmo.err", err, 4);
      check("tmo.busy", busy, 0);
      check("tmo.cpu_rst_n", cpu_rst_n, 0);
      check("tmo.writes", wq.size(), 0);

      // A byte landing on the timeout edge keeps the frame alive.
      wq.delete();
      send(8'hA5);
      send(8'h01);
      idle(15);
      send(8'h00);
      check("race.err", err, 0);
      check("race.busy", busy, 1);
      send(8'h11);
      send(8'h22);
`ifdef PROG_LOADER_CHECKSUM_EN
      send(8'h32);
`endif
      idle(3);
      check("race.writes", wq.size(), 1);
      if (wq.size() > 0) check("race.w0", wq[0], {10'd0, 16'h2211});
      check("race.done", done, 1);
      check("race.err_end", err, 0);

      // Reset after one word of a two-word frame, then a fresh load from address 0.
      wq.delete();
      send(8'hA5); send(8'h02); send(8'h00); send(8'h34); send(8'h12);
      idle(1);
      check("midrst.pre_writes", wq.size(), 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst.mem_we", mem_we, 0);
      check("midrst.mem_addr", mem_addr, 0);
      check("midrst.mem_wdata", mem_wdata, 0);
      check("midrst.busy", busy, 0);
      check("midrst.done", done, 0);
      check("midrst.err", err, 0);
      check("midrst.cpu_rst_n", cpu_rst_n, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      check("midrst.no_writes", wq.size(), 1);
      wq.delete();
      send(8'hA5); send(8'h01); send(8'h00); send(8'hCD); send(8'hAB);
`ifdef PROG_LOADER_CHECKSUM_EN
      send(8'h67);
`endif
      idle(3);
      check("reload.writes", wq.size(), 1);
      if (wq.size() > 0) check("reload.w0", wq[0], {10'd0, 16'hABCD});
      check("reload.done", done, 1);
      check("reload.cpu_rst_n", cpu_rst_n, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter PROGRAM_SIZE, default 1024, program memory depth in 16-bit words.
REQ-002 Parameter MAGIC, default 8'hA5, load-start byte.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000, maximum idle clocks between bytes inside a load.
REQ-004 Ports, in order:
- clk, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- rx_data, in, 8, byte from UART receiver.
- rx_valid, in, 1, rx_data valid.
- rx_ready, out, 1, byte accepted when rx_valid && rx_ready.
- mem_we, out, 1, program BRAM write strobe.
- mem_addr, out, clog2(PROGRAM_SIZE), BRAM write word address.
- mem_wdata, out, 16, BRAM write data.
- cpu_rst_n, out, 1, active-low reset to the cpu7 SoC.
- busy, out, 1, load in progress.
- done, out, 1, last load succeeded.
- err, out, 3, last error code.

Function
REQ-005 Frame: MAGIC, LEN_LO, LEN_HI, N x (WORD_LO, WORD_HI), [CSUM]; N = {LEN_HI,LEN_LO}, in words.
REQ-006 States: S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CSUM, S_DONE, S_ERR.
REQ-007 rx_ready SHALL be 1 in every state; at most one byte is consumed per clock.
REQ-008 In S_IDLE, S_DONE and S_ERR, a non-MAGIC byte SHALL be discarded and MAGIC SHALL move to S_LEN_LO with busy=1, done=0, err=0, cpu_rst_n=0, and the word index cleared.
REQ-009 S_LEN_LO -> S_LEN_HI -> S_DATA_LO on accepted bytes.
REQ-010 After LEN_HI, N=0 SHALL go to S_ERR with err=1; N>PROGRAM_SIZE SHALL go to S_ERR with err=2.
REQ-011 The WORD_LO byte is latched and the state moves to S_DATA_HI.
REQ-012 On the WORD_HI byte, the next cycle SHALL assert mem_we for exactly one clock, with mem_wdata={WORD_HI,WORD_LO} and mem_addr=word index.
REQ-013 The word index SHALL increment after each write.
REQ-014 After the Nth write, the next state is S_CSUM, or S_DONE when checksum is disabled.
REQ-015 Entering S_DONE SHALL set done=1, busy=0 and cpu_rst_n=1.
REQ-016 Entering S_ERR SHALL set busy=0 and keep cpu_rst_n=0.
REQ-017 The idle counter SHALL clear on every accepted byte and otherwise count while busy.
REQ-018 When the counter reaches TIMEOUT_CYCLES, the state SHALL go to S_ERR with err=4.
REQ-019 When a byte is accepted in the same cycle as the counter reaches TIMEOUT_CYCLES, the byte SHALL win and no timeout occurs.
REQ-020 A MAGIC byte inside a frame SHALL be treated as data, not as a restart.
REQ-021 mem_addr SHALL never reach PROGRAM_SIZE (guaranteed by REQ-010).

Reset
REQ-022 With rst_n=0 at a clock edge, all of the following SHALL hold on the next cycle:
- state=S_IDLE;
- mem_we=0, mem_addr=0, mem_wdata=0;
- cpu_rst_n=0, busy=0, done=0, err=0;
- counters and checksum cleared.
REQ-023 Reset asserted mid-load SHALL abandon the frame; no further mem_we SHALL occur.

Configuration
REQ-024 With PROG_LOADER_CHECKSUM_EN defined:
- the checksum SHALL be the 8-bit XOR of every byte from LEN_LO through the last WORD_HI;
- S_CSUM SHALL compare the received byte to the checksum: match goes to S_DONE, mismatch goes to S_ERR with err=3.
REQ-025 With PROG_LOADER_CHECKSUM_EN undefined:
- S_CSUM and the checksum register SHALL be absent;
- err=3 SHALL never occur.

Structure
REQ-026 Package cpu7_pkg SHALL hold the loader state enum and the error-code constants:
- ERR_NONE=0;
- ERR_LEN_ZERO=1;
- ERR_LEN_OVF=2;
- ERR_CSUM=3;
- ERR_TIMEOUT=4.
REQ-027 A single flat module SHALL be used, with no sub-modules; the UART receiver is external.

Verification
REQ-028 Frame A5 02 00 34 12 78 56 (checksum off) SHALL produce:
- mem_we at addr 0 with data 1234, then at addr 1 with data 5678;
- then done=1, cpu_rst_n=1, err=0.
REQ-029 Frame A5 00 00 SHALL produce err=1, cpu_rst_n=0 and no mem_we.
REQ-030 Frame A5 01 04 (N=1025, PROGRAM_SIZE=1024) SHALL produce err=2 and no mem_we.
REQ-031 With checksum on, A5 01 00 CD AB 67 SHALL produce done=1.
REQ-032 With checksum on, the same frame with the final byte 00 SHALL produce err=3 after a single write of ABCD at addr 0.
REQ-033 With TIMEOUT_CYCLES=16, A5 01 followed by silence SHALL give err=4 exactly 16 clocks after the last byte.
REQ-034 Asserting rst_n=0 mid-frame after one word SHALL clear the outputs; a fresh frame SHALL then load from addr 0.
